flit_source: RTL and testbench

Two-phase (toggle) handshake traffic generator feeding a single sink stage in the NoC test fabric. Emits a sequence of `SIZE-bit flits, one per handshake, spaced by a programmable idle gap, and stops after a programmed count. Sits directly upstream of the sink: its req/data drive the sink's req/data, and the sink's ack returns here.

---
 rtl/flit_source_pkg.sv | 22 ++
 rtl/flit_source_ack_sync.sv | 26 ++
 rtl/flit_source.sv | 96 +++++++++
 tb/tb_flit_source.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_source_pkg.sv
// Shared defines and package for the flit_source family: flit width, handshake
// state encoding and the saturating sent-counter helper.
`ifndef SIZE
`define SIZE 8
`endif

package flit_source_pkg;

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } flit_state_t;

    localparam logic [31:0] SENT_MAX        = 32'hFFFF_FFFF;
    localparam int          ACK_SYNC_STAGES = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == SENT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/flit_source_ack_sync.sv
// Two-flop reset-clearing synchronizer for the returning ack level.
// Only compiled in when FLIT_SOURCE_ACK_SYNC_EN is defined.
`ifdef FLIT_SOURCE_ACK_SYNC_EN
module flit_source_ack_sync
    import flit_source_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic synced
);

    logic [ACK_SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[ACK_SYNC_STAGES-2:0], level};
        end
    end

    assign synced = stages[ACK_SYNC_STAGES-1];

endmodule
`endif

// File: rtl/flit_source.sv
// Two-phase handshake flit generator with programmable gap and flit count.
// Define FLIT_SOURCE_ACK_SYNC_EN to pass ack through a 2-flop synchronizer.
`ifndef SIZE
`define SIZE 8
`endif

module flit_source
    import flit_source_pkg::*;
#(
    parameter int GAP   = 0,
    parameter int COUNT = 0,
    parameter int BASE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              ack,
    output logic              req,
    output logic [`SIZE-1:0]  data,
    output logic [31:0]       sent,
    output logic              done,
    output logic              err
);

    localparam int          W       = `SIZE;
    localparam logic [W-1:0] BASE_L = W'(BASE);
    localparam logic [31:0] GAP_L   = 32'(GAP);
    localparam logic [31:0] COUNT_L = 32'(COUNT);

    flit_state_t  state;
    logic [31:0]  gap_cnt;
    logic [W-1:0] seq;
    logic         ack_s;

`ifdef FLIT_SOURCE_ACK_SYNC_EN
    flit_source_ack_sync ack_sync (
        .clk    (clk),
        .reset  (reset),
        .level  (ack),
        .synced (ack_s)
    );
`else
    assign ack_s = ack;
`endif

    // An ack that differs from req while nothing is outstanding is a sink fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_GAP;
            req     <= 1'b0;
            data    <= BASE_L;
            sent    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            gap_cnt <= '0;
            seq     <= '0;
        end else begin
            case (state)
                ST_GAP: begin
                    if (ack_s != req) begin
                        err <= 1'b1;
                    end
                    if (gap_cnt != 32'd0) begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end else if (en) begin
                        req   <= ~req;
                        data  <= BASE_L + seq;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ack_s == req) begin
                        seq     <= seq + 1'b1;
                        sent    <= sat_inc(sent);
                        gap_cnt <= GAP_L;
                        if ((COUNT_L != 32'd0) && (sat_inc(sent) == COUNT_L)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_DONE: begin
                    if (ack_s != req) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_GAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flit_source.sv
// Self-checking bench for flit_source: two instances against a timestamp-based
// reference model and a behavioural two-phase sink.
`ifndef SIZE
`define SIZE 8
`endif

module tb_flit_source;

    localparam int W = `SIZE;
`ifdef FLIT_SOURCE_ACK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int GAP0 = 0, COUNT0 = 4, BASE0 = 10;
    localparam int GAP1 = 2, COUNT1 = 0;
    localparam int BASE1 = (1 << W) - 3;
    localparam int P0 = 3 + GAP0 + LAT;
    localparam int P1 = 3 + GAP1 + LAT;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   en_v = '0;
    logic [1:0]   sink_ack = '0;
    logic [1:0]   pulse = '0;
    wire  [1:0]   req_v, done_v, err_v;
    wire  [W-1:0] data0, data1;
    wire  [31:0]  sent0, sent1;

    always #5 clk = ~clk;

    flit_source #(.GAP(GAP0), .COUNT(COUNT0), .BASE(BASE0)) dut0 (
        .clk(clk), .reset(reset), .en(en_v[0]), .ack(sink_ack[0] ^ pulse[0]),
        .req(req_v[0]), .data(data0), .sent(sent0), .done(done_v[0]), .err(err_v[0]));

    flit_source #(.GAP(GAP1), .COUNT(COUNT1), .BASE(BASE1)) dut1 (
        .clk(clk), .reset(reset), .en(en_v[1]), .ack(sink_ack[1] ^ pulse[1]),
        .req(req_v[1]), .data(data1), .sent(sent1), .done(done_v[1]), .err(err_v[1]));

    int errors = 0;
    int checks = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: per instance, rules of the handshake in terms of timestamps.
    bit          m_req [2];
    logic [W-1:0] m_data [2];
    longint      m_sent [2];
    int          m_seq [2];
    bit          m_done [2], m_err [2], m_out [2];
    longint      m_next [2];
    bit          m_h0 [2], m_h1 [2];
    int          edge_n = 0;

    function automatic int gap_of(input int i);  return (i == 0) ? GAP0 : GAP1;  endfunction
    function automatic int cnt_of(input int i);  return (i == 0) ? COUNT0 : COUNT1; endfunction
    function automatic int base_of(input int i); return (i == 0) ? BASE0 : BASE1; endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 0; m_data[i] = W'(base_of(i)); m_sent[i] = 0; m_seq[i] = 0;
            m_done[i] = 0; m_err[i] = 0; m_out[i] = 0; m_next[i] = 0;
            m_h0[i] = 0; m_h1[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        bit ack_now;
        bit ack_s;
        ack_now = sink_ack[i] ^ pulse[i];
        ack_s   = (LAT == 0) ? ack_now : m_h1[i];
        m_h1[i] = m_h0[i];
        m_h0[i] = ack_now;
        if (m_done[i]) begin
            if (ack_s != m_req[i]) m_err[i] = 1;
        end else if (m_out[i]) begin
            if (ack_s == m_req[i]) begin
                if (m_sent[i] < 64'hFFFF_FFFF) m_sent[i]++;
                m_seq[i]++;
                m_out[i]  = 0;
                m_next[i] = edge_n + gap_of(i) + 1;
                if (cnt_of(i) != 0 && m_sent[i] == cnt_of(i)) m_done[i] = 1;
            end
        end else begin
            if (ack_s != m_req[i]) m_err[i] = 1;
            if (edge_n >= m_next[i] && en_v[i]) begin
                m_req[i]  = ~m_req[i];
                m_data[i] = W'(base_of(i) + m_seq[i]);
                m_out[i]  = 1;
            end
        end
    endtask

    // Sink: acknowledges a few edges after it sees a new req level.
    bit   sink_pend [2];
    int   sink_cnt [2];
    bit   rand_delay = 0;
    bit   prev_req [2];
    int   tog_cnt [2];
    int   tog_edge0 [$];
    int   tog_data0 [$];
    int   tog_data1 [$];
    int   done0_edge, hit100;

    function automatic logic [63:0] get_data(input int i); return (i == 0) ? 64'(data0) : 64'(data1); endfunction
    function automatic logic [63:0] get_sent(input int i); return (i == 0) ? 64'(sent0) : 64'(sent1); endfunction

    task automatic tick();
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("req%0d", i),  64'(req_v[i]),  64'(m_req[i]));
            check_output($sformatf("data%0d", i), get_data(i),    64'(m_data[i]));
            check_output($sformatf("sent%0d", i), get_sent(i),    64'(m_sent[i]));
            check_output($sformatf("done%0d", i), 64'(done_v[i]), 64'(m_done[i]));
            check_output($sformatf("err%0d", i),  64'(err_v[i]),  64'(m_err[i]));
            if (req_v[i] !== prev_req[i]) begin
                tog_cnt[i]++;
                if (i == 0) begin
                    tog_edge0.push_back(edge_n);
                    tog_data0.push_back(int'(data0));
                end else begin
                    tog_data1.push_back(int'(data1));
                end
            end
            prev_req[i] = req_v[i];
            if (sink_pend[i]) begin
                sink_cnt[i]--;
                if (sink_cnt[i] == 0) begin
                    sink_ack[i]  = req_v[i];
                    sink_pend[i] = 0;
                end
            end
            if (!sink_pend[i] && req_v[i] !== sink_ack[i]) begin
                sink_pend[i] = 1;
                sink_cnt[i]  = rand_delay ? int'($urandom_range(1, 4)) : 1;
            end
        end
        if (done_v[0] && done0_edge < 0) done0_edge = edge_n;
        if (sent1 == 32'd100 && hit100 < 0) hit100 = edge_n;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        sink_ack = '0; pulse = '0; en_v = '0;
        model_reset();
        repeat (cycles) @(negedge clk);
        check_output("rst_req0",  64'(req_v[0]), 64'(0));
        check_output("rst_req1",  64'(req_v[1]), 64'(0));
        check_output("rst_data0", 64'(data0), 64'(BASE0));
        check_output("rst_data1", 64'(data1), 64'(BASE1));
        check_output("rst_sent0", 64'(sent0), 64'(0));
        check_output("rst_sent1", 64'(sent1), 64'(0));
        check_output("rst_done",  64'(done_v), 64'(0));
        check_output("rst_err",   64'(err_v), 64'(0));
        for (int i = 0; i < 2; i++) begin
            sink_pend[i] = 0; sink_cnt[i] = 0; prev_req[i] = 0; tog_cnt[i] = 0;
        end
        tog_edge0.delete(); tog_data0.delete(); tog_data1.delete();
        done0_edge = -1; hit100 = -1;
        edge_n = 0;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] exp_d;

        // Directed timing: both sources free-running, sink answers one edge later.
        do_reset(3);
        en_v = 2'b11;
        while (sent1 < 32'd100 && edge_n < 3000) tick();
        check_output("tog_count0", 64'(tog_cnt[0]), 64'(4));
        for (int k = 0; k < 4 && k < tog_edge0.size(); k++) begin
            check_output($sformatf("tog_edge0_%0d", k), 64'(tog_edge0[k]), 64'(1 + k * P0));
            check_output($sformatf("tog_data0_%0d", k), 64'(tog_data0[k]), 64'(BASE0 + k));
        end
        check_output("done0_edge", 64'(done0_edge), 64'(1 + 3 * P0 + 2 + LAT));
        check_output("sent0_final", 64'(sent0), 64'(4));
        check_output("hit100_edge", 64'(hit100), 64'(1 + 99 * P1 + 2 + LAT));
        check_output("done1_unlimited", 64'(done_v[1]), 64'(0));
        if (tog_data1.size() > 3)
            check_output("wrap_data1", 64'(tog_data1[3]), 64'((BASE1 + 3) % (1 << W)));
        else
            check_output("wrap_seen", 64'(tog_data1.size()), 64'(4));

        // en dropped while a handshake is outstanding.
        do_reset(2);
        en_v = 2'b11;
        for (int k = 0; k < 20 && tog_cnt[0] < 1; k++) tick();
        check_output("first_req", 64'(tog_cnt[0]), 64'(1));
        en_v = 2'b00;
        repeat (20) tick();
        check_output("wait_complete", 64'(sent0), 64'(1));
        check_output("no_new_req", 64'(tog_cnt[0]), 64'(1));
        en_v = 2'b11;
        for (int k = 0; k < 10 && tog_cnt[0] < 2; k++) tick();
        check_output("req_after_en", 64'(tog_cnt[0]), 64'(2));

        // Spurious ack pulse while instance 1 is idle.
        en_v = 2'b00;
        for (int k = 0; k < 60 && !(m_out[1] == 0 && m_next[1] <= edge_n && !sink_pend[1]); k++) tick();
        exp_d = m_data[1];
        pulse[1] = 1'b1;
        tick();
        pulse[1] = 1'b0;
        repeat (LAT + 2) tick();
        check_output("spurious_err", 64'(err_v[1]), 64'(1));
        check_output("spurious_data", 64'(data1), 64'(exp_d));
        en_v = 2'b11;
        repeat (30) tick();
        check_output("err_sticky", 64'(err_v[1]), 64'(1));

        // Reset one cycle after the second request toggle.
        do_reset(2);
        en_v = 2'b11;
        for (int k = 0; k < 40 && tog_cnt[0] < 2; k++) tick();
        check_output("second_req", 64'(tog_cnt[0]), 64'(2));
        tick();
        do_reset(2);
        en_v = 2'b11;
        for (int k = 0; k < 20 && tog_cnt[0] < 1; k++) tick();
        check_output("restart_toggles", 64'(tog_cnt[0]), 64'(1));
        if (tog_data0.size() > 0)
            check_output("restart_data", 64'(tog_data0[0]), 64'(BASE0));

        // Randomized enables, sink delays and occasional spurious pulses.
        rand_delay = 1;
        do_reset(2);
        for (int k = 0; k < 800; k++) begin
            en_v[0] = ($urandom_range(0, 3) != 0);
            en_v[1] = ($urandom_range(0, 3) != 0);
            pulse[1] = ($urandom_range(0, 59) == 0);
            if (k == 400) begin
                pulse = '0;
                do_reset(1);
            end
            tick();
        end
        pulse = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
